hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
Parametrised successor to the pipeline's hazard unit. Covers forwarding, load-use stall and branch flush for the 5-stage RISC-V pipeline. Adds a multi-cycle execute-op sequencer (MUL/DIV occupying E for MC_LATENCY cycles) with its own FSM and counter. Adds a compile-time no-forwarding mode. Sits beside controller and datapath in the pipeline top and drives all stall, flush and forward selects.

Parameters:
REG_AW, 5, register-address width (Rs/Rd fields).
MC_LATENCY, 4, cycles a multi-cycle op occupies E; legal range 2..255.
FWD_EN, 1, 1 = forward from M/W; 0 = no forwarding, stall D on every RAW hit against E or M.
CNT_W, $clog2(MC_LATENCY), counter width (derived; do not override).

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset).
Rs1D, Rs2D  in  REG_AW  source registers in D.
Rs1E, Rs2E, RdE  in  REG_AW  sources and destination in E.
RdM, RdW  in  REG_AW  destinations in M and W.
RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage.
ResultSrcb0E  in  1  load in E.
PCSrcE  in  1  taken branch or jump resolved in E.
McStartE  in  1  multi-cycle op in E; held high while that op remains in E.
ForwardAE, ForwardBE  out  2  00 = regfile/E, 01 = ResultW, 10 = ALUResultM.
StallF, StallD, StallE  out  1  hold PC, IF/ID and ID/EX registers.
FlushD, FlushE, FlushM  out  1  zero IF/ID, ID/EX and EX/MEM registers.
McBusy  out  1  registered; FSM in BUSY.
McDone  out  1  op in E completes this cycle.
McCount  out  CNT_W  registered remaining-cycle counter.

Behaviour:
- Reset (reset=0 at an edge): FSM to IDLE, McCount=0, McBusy=0. Reset mid-op abandons the op with no completion pulse. While reset is low the FSM-derived terms are 0: no MC stall, McDone=0.
- Forwarding (FWD_EN=1), per operand X in {1,2}:
  - 10 if RsXE==RdM, RegWriteM=1 and RsXE!=0.
  - Else 01 if RsXE==RdW, RegWriteW=1 and RsXE!=0.
  - Else 00. M has priority over W.
  - FWD_EN=0: ForwardAE and ForwardBE are tied to 00.
- lwStall = ResultSrcb0E, RdE!=0, and (Rs1D==RdE or Rs2D==RdE).
- rawStall (FWD_EN=0 only): some RsXD!=0 matches RdE with RegWriteE=1, or matches RdM with RegWriteM=1. W needs no stall because the regfile is write-first.
- FSM, states IDLE and BUSY:
  - IDLE with McStartE=1: mcStall=1 this cycle. Next state BUSY, McCount<=MC_LATENCY-2.
  - BUSY with McCount>0: mcStall=1, McCount decrements.
  - BUSY with McCount==0: McDone=1, mcStall=0, next state IDLE. McStartE is ignored in BUSY, so the same op is never restarted.
  - Net effect: mcStall is high for exactly MC_LATENCY-1 cycles, McDone for 1 cycle, then the op advances to M.
- Outputs (combinational from inputs and state):
  - StallF = lwStall | rawStall | mcStall.
  - StallD = lwStall | rawStall | mcStall.
  - StallE = mcStall.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | ((lwStall | rawStall) & ~mcStall).
  - FlushM = mcStall, so bubbles enter M while E is held.
- Simultaneous events:
  - mcStall beats lwStall/rawStall: E is frozen, so no E flush and D is held.
  - PCSrcE together with McStartE cannot occur (decoder guarantee); if it does, PCSrcE flushes win and the FSM still sequences.
- Bubbles injected by FlushM carry RegWriteM=0 (datapath guarantee), so nothing is forwarded from them.

Test Plan:
- Forward priority: Rs1E=5, RdM=5, RdW=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Rs1E=0 -> 00.
- Load-use: ResultSrcb0E=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. RdE=0 -> no stall.
- Branch: PCSrcE=1 -> FlushD=FlushE=1, StallF=0. Combined with a load-use hit, both flushes remain 1.
- MC op, MC_LATENCY=4: McStartE rises at cycle 0 -> StallF/D/E=1 and FlushM=1 for cycles 0-2, McCount 2,1,0 over cycles 1-3, McDone=1 in cycle 3, IDLE in cycle 4. Re-run with MC_LATENCY=2 -> 1 stall cycle.
- Reset mid-op: reset=0 during cycle 1 of a 4-cycle op -> next cycle McBusy=0, McCount=0, no McDone, stalls drop.
- FWD_EN=0: RdM=3, RegWriteM=1, Rs1D=3 -> StallD=1, FlushE=1, ForwardAE=00. A W-only match -> no stall.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use/RAW stalls, branch
// flush and a multi-cycle execute sequencer that holds E for MC_LATENCY cycles.

module hazard_fwd_lane #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        fwd,
  output logic              raw_hit
);
  always_comb begin
    fwd     = 2'b00;
    raw_hit = 1'b0;
    if (FWD_EN) begin
      if (rs_e != '0 && rs_e == rd_m && reg_write_m)      fwd = 2'b10;
      else if (rs_e != '0 && rs_e == rd_w && reg_write_w) fwd = 2'b01;
    end else begin
      // regfile is write-first, so a W producer never needs a stall
      raw_hit = (rs_d != '0) &&
                ((rs_d == rd_e && reg_write_e) || (rs_d == rd_m && reg_write_m));
    end
  end
endmodule

module hazard_unit_mc #(
  parameter int REG_AW     = 5,
  parameter int MC_LATENCY = 4,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = $clog2(MC_LATENCY)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcb0E,
  input  logic              PCSrcE,
  input  logic              McStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              McBusy,
  output logic              McDone,
  output logic [CNT_W-1:0]  McCount
);
  localparam int NUM_OPS = 2;
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LATENCY - 2);

  typedef enum logic {IDLE, BUSY} mc_state_t;

  logic [NUM_OPS-1:0][REG_AW-1:0] rs_d, rs_e;
  logic [NUM_OPS-1:0][1:0]        fwd;
  logic [NUM_OPS-1:0]             raw_hit;

  assign rs_d = {Rs2D, Rs1D};
  assign rs_e = {Rs2E, Rs1E};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    hazard_fwd_lane #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_lane (
      .rs_d        (rs_d[i]),
      .rs_e        (rs_e[i]),
      .rd_e        (RdE),
      .rd_m        (RdM),
      .rd_w        (RdW),
      .reg_write_e (RegWriteE),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .fwd         (fwd[i]),
      .raw_hit     (raw_hit[i])
    );
  end

  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

  logic lw_stall, raw_stall, mc_stall, mc_done;

  assign lw_stall  = ResultSrcb0E && (RdE != '0) && (Rs1D == RdE || Rs2D == RdE);
  assign raw_stall = |raw_hit;

  mc_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // McStartE is ignored in BUSY so the same op is never restarted
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    mc_done  = 1'b0;
    case (state_q)
      IDLE: if (McStartE) begin
        mc_stall = 1'b1;
        state_d  = BUSY;
        cnt_d    = MC_LOAD;
      end
      BUSY: if (cnt_q != '0) begin
        mc_stall = 1'b1;
        cnt_d    = cnt_q - 1'b1;
      end else begin
        mc_done  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      mc_stall = 1'b0;
      mc_done  = 1'b0;
    end
  end

  assign McBusy  = (state_q == BUSY);
  assign McDone  = mc_done;
  assign McCount = cnt_q;

  // E is frozen during an MC op, so a D-side hazard must not bubble E
  assign StallF = lw_stall | raw_stall | mc_stall;
  assign StallD = lw_stall | raw_stall | mc_stall;
  assign StallE = mc_stall;
  assign FlushD = PCSrcE;
  assign FlushE = PCSrcE | ((lw_stall | raw_stall) & ~mc_stall);
  assign FlushM = mc_stall;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: default, 2-cycle MC and no-forwarding builds
// share one stimulus; expectations are queued per cycle and drained before the edge.

module tb_hazard_unit_mc;
  logic       clk, reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcb0E, PCSrcE, McStartE;

  logic [1:0] fa, fb, fa_nf, fb_nf, fa_2, fb_2;
  logic       sf, sd, se, fd, fe, fm, busy, done;
  logic       sf_nf, sd_nf, se_nf, fd_nf, fe_nf, fm_nf, busy_nf, done_nf;
  logic       sf_2, sd_2, se_2, fd_2, fe_2, fm_2, busy_2, done_2;
  logic [1:0] cnt, cnt_nf;
  logic [0:0] cnt_2;

  hazard_unit_mc u_dut (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcb0E(ResultSrcb0E), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .ForwardAE(fa), .ForwardBE(fb), .StallF(sf), .StallD(sd), .StallE(se), .FlushD(fd),
    .FlushE(fe), .FlushM(fm), .McBusy(busy), .McDone(done), .McCount(cnt));

  hazard_unit_mc #(.MC_LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcb0E(ResultSrcb0E), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .ForwardAE(fa_2), .ForwardBE(fb_2), .StallF(sf_2), .StallD(sd_2), .StallE(se_2), .FlushD(fd_2),
    .FlushE(fe_2), .FlushM(fm_2), .McBusy(busy_2), .McDone(done_2), .McCount(cnt_2));

  hazard_unit_mc #(.FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcb0E(ResultSrcb0E), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .ForwardAE(fa_nf), .ForwardBE(fb_nf), .StallF(sf_nf), .StallD(sd_nf), .StallE(se_nf), .FlushD(fd_nf),
    .FlushE(fe_nf), .FlushM(fm_nf), .McBusy(busy_nf), .McDone(done_nf), .McCount(cnt_nf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    O_FA, O_FB, O_SF, O_SD, O_SE, O_FD, O_FE, O_FM, O_BUSY, O_DONE, O_CNT,
    O_SD2, O_DONE2, O_CNT2, O_FA_NF, O_SF_NF, O_SD_NF, O_FE_NF
  } obs_t;

  typedef struct {
    string      tag;
    obs_t       id;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] obs(obs_t id);
    case (id)
      O_FA:    return 8'(fa);
      O_FB:    return 8'(fb);
      O_SF:    return 8'(sf);
      O_SD:    return 8'(sd);
      O_SE:    return 8'(se);
      O_FD:    return 8'(fd);
      O_FE:    return 8'(fe);
      O_FM:    return 8'(fm);
      O_BUSY:  return 8'(busy);
      O_DONE:  return 8'(done);
      O_CNT:   return 8'(cnt);
      O_SD2:   return 8'(sd_2);
      O_DONE2: return 8'(done_2);
      O_CNT2:  return 8'(cnt_2);
      O_FA_NF: return 8'(fa_nf);
      O_SF_NF: return 8'(sf_nf);
      O_SD_NF: return 8'(sd_nf);
      O_FE_NF: return 8'(fe_nf);
      default: return 8'hxx;
    endcase
  endfunction

  task automatic push(input string tag, input obs_t id, input logic [7:0] val);
    exp_t e;
    e.tag = tag; e.id = id; e.val = val;
    sb.push_back(e);
  endtask

  // sample 1ns after inputs settle, well away from the rising edge
  task automatic drain();
    exp_t       e;
    logic [7:0] got;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = obs(e.id);
      checks++;
      assert (got === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic clr();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, ResultSrcb0E, PCSrcE, McStartE} = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    clr();
    reset = 1'b0;
    cyc(); cyc();
    push("rst_busy", O_BUSY, 0); push("rst_cnt", O_CNT, 0);
    push("rst_stallE", O_SE, 0); push("rst_done", O_DONE, 0); push("rst_flushM", O_FM, 0);
    drain();
    reset = 1'b1;

    // forwarding priority
    cyc(); clr();
    Rs1E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
    Rs2E = 6;
    push("fwdA_M", O_FA, 2); push("fwdB_none", O_FB, 0); push("fwdA_nofwd", O_FA_NF, 0);
    drain();
    cyc(); RegWriteM = 0; Rs2E = 5;
    push("fwdA_W", O_FA, 1); push("fwdB_W", O_FB, 1); drain();
    cyc(); Rs1E = 0; RdW = 0;
    push("fwdA_x0", O_FA, 0); drain();

    // load-use
    cyc(); clr();
    ResultSrcb0E = 1; RdE = 7; Rs2D = 7;
    push("lw_stallF", O_SF, 1); push("lw_stallD", O_SD, 1); push("lw_flushE", O_FE, 1);
    push("lw_stallE", O_SE, 0); push("lw_flushD", O_FD, 0);
    drain();
    cyc(); RdE = 0; Rs2D = 0;
    push("lw_x0_stallD", O_SD, 0); push("lw_x0_flushE", O_FE, 0); drain();

    // branch, alone and with a load-use hit
    cyc(); clr(); PCSrcE = 1;
    push("br_flushD", O_FD, 1); push("br_flushE", O_FE, 1); push("br_stallF", O_SF, 0); drain();
    cyc(); ResultSrcb0E = 1; RdE = 9; Rs1D = 9;
    push("brlw_flushD", O_FD, 1); push("brlw_flushE", O_FE, 1); push("brlw_stallF", O_SF, 1); drain();

    // multi-cycle op, MC_LATENCY=4 (and 2 in u_lat2 for its first two cycles)
    cyc(); clr(); McStartE = 1;
    push("mc0_stallF", O_SF, 1); push("mc0_stallE", O_SE, 1); push("mc0_flushM", O_FM, 1);
    push("mc0_busy", O_BUSY, 0); push("mc0_done", O_DONE, 0);
    push("l2c0_stallD", O_SD2, 1); push("l2c0_done", O_DONE2, 0);
    drain();
    cyc();
    push("mc1_stallD", O_SD, 1); push("mc1_busy", O_BUSY, 1); push("mc1_cnt", O_CNT, 2);
    push("mc1_done", O_DONE, 0);
    push("l2c1_stallD", O_SD2, 0); push("l2c1_done", O_DONE2, 1); push("l2c1_cnt", O_CNT2, 0);
    drain();
    cyc(); ResultSrcb0E = 1; RdE = 7; Rs1D = 7;
    push("mc2_cnt", O_CNT, 1); push("mc2_stallE", O_SE, 1);
    push("mc2lw_flushE", O_FE, 0); push("mc2lw_stallD", O_SD, 1); push("mc2_flushM", O_FM, 1);
    drain();
    cyc(); ResultSrcb0E = 0; RdE = 0; Rs1D = 0;
    push("mc3_cnt", O_CNT, 0); push("mc3_done", O_DONE, 1); push("mc3_stallE", O_SE, 0);
    push("mc3_stallF", O_SF, 0); push("mc3_flushM", O_FM, 0); push("mc3_busy", O_BUSY, 1);
    drain();
    cyc(); McStartE = 0;
    push("mc4_busy", O_BUSY, 0); push("mc4_done", O_DONE, 0); push("mc4_stallE", O_SE, 0); drain();
    cyc(); cyc();

    // reset during cycle 1 of an op
    cyc(); McStartE = 1;
    push("rmc0_stallE", O_SE, 1); drain();
    cyc(); reset = 0;
    push("rmc1_stallE", O_SE, 0); push("rmc1_done", O_DONE, 0); push("rmc1_cnt", O_CNT, 2); drain();
    cyc(); reset = 1; McStartE = 0;
    push("rmc2_busy", O_BUSY, 0); push("rmc2_cnt", O_CNT, 0); push("rmc2_done", O_DONE, 0);
    push("rmc2_stallF", O_SF, 0); push("rmc2_stallE", O_SE, 0);
    drain();
    cyc();
    push("rmc3_done", O_DONE, 0); push("rmc3_busy", O_BUSY, 0); drain();

    // no-forwarding build
    cyc(); clr(); RdM = 3; RegWriteM = 1; Rs1D = 3; Rs1E = 3;
    push("nf_M_stallD", O_SD_NF, 1); push("nf_M_stallF", O_SF_NF, 1); push("nf_M_flushE", O_FE_NF, 1);
    push("nf_fwdA", O_FA_NF, 0); push("fw_M_stallD", O_SD, 0); push("fw_fwdA", O_FA, 2);
    drain();
    cyc(); clr(); RdW = 3; RegWriteW = 1; Rs2D = 3;
    push("nf_W_stallD", O_SD_NF, 0); push("nf_W_flushE", O_FE_NF, 0); drain();
    cyc(); clr(); RdE = 4; RegWriteE = 1; Rs2D = 4;
    push("nf_E_stallD", O_SD_NF, 1); drain();
    cyc(); RegWriteE = 0;
    push("nf_E_nowr", O_SD_NF, 0); drain();
    cyc(); clr(); RegWriteE = 1; RegWriteM = 1;
    push("nf_x0_stallD", O_SD_NF, 0); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
